// File: rtl/imem_loader.sv
// Instruction-memory program loader: host byte stream -> big-endian words, CPU held until image is valid.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int NMEM = 20,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          im_we,
    output logic [AW-1:0] im_waddr,
    output logic [31:0]   im_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_cnt
);
    localparam logic [15:0] NMEM_L = 16'(NMEM);

    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, LOAD, DONE, ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    state_t      state;
    logic [15:0] len_p0;
    logic [23:0] word_p0;
    logic [1:0]  byte_cnt;
    logic        xfer;
    logic [15:0] len_now;
    logic [15:0] next_cnt;
    logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign xfer      = in_valid && in_ready;
    assign len_now   = {len_p0[15:8], in_data};
    assign next_cnt  = 16'(word_cnt) + 16'd1;
    assign last_word = (next_cnt == len_p0);

    // Stage p0: header and partial-word capture (data path, not reset)
    always_ff @(posedge clk) begin
        if (xfer && state == HDR_HI) len_p0[15:8] <= in_data;
        if (xfer && state == HDR_LO) len_p0[7:0]  <= in_data;
        if (xfer && state == LOAD)   word_p0      <= {word_p0[15:0], in_data};
    end

    // Stage p1: control FSM and registered memory write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            im_we    <= 1'b0;
            im_waddr <= '0;
            im_wdata <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
            byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= HDR_HI;
                        in_ready <= 1'b1;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        word_cnt <= '0;
                        byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                HDR_HI: begin
                    if (xfer) state <= HDR_LO;
                end
                HDR_LO: begin
                    if (xfer) begin
                        if (len_now == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state    <= CHK;
`else
                            state    <= DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else if (len_now > NMEM_L) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            im_we    <= 1'b1;
                            im_waddr <= word_cnt[AW-1:0];
                            im_wdata <= {word_p0, in_data};
                            word_cnt <= next_cnt[AW:0];
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state    <= CHK;
`else
                                state    <= DONE;
                                in_ready <= 1'b0;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
